// File: rtl/alu_sys_pkg.sv
// Shared constants and FSM encoding for the ALU result serializer slice.
package alu_sys_pkg;

    localparam int ALU_OUT_W      = 16;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = ALU_OUT_W / BYTE_W;

    localparam logic [7:0] SER_HDR = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } ser_state_e;

endpackage

// File: rtl/alu_result_serializer_if.sv
// Result-in / byte-out bundle of the serializer; master is the ALU/sink side, slave the serializer.
interface alu_result_serializer_if
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_OUT_W,
    parameter int FIFO_DEPTH = 4
);

    logic [DATA_WIDTH-1:0]          IN_DATA;
    logic                           IN_VALID;
    logic [BYTE_W-1:0]              TX_DATA;
    logic                           TX_VALID;
    logic                           TX_READY;
    logic                           OVERFLOW;
    logic                           CLR_OVF;
    logic [$clog2(FIFO_DEPTH):0]    FIFO_COUNT;
    logic                           BUSY;

    modport master (
        output IN_DATA, IN_VALID, TX_READY, CLR_OVF,
        input  TX_DATA, TX_VALID, OVERFLOW, FIFO_COUNT, BUSY
    );

    modport slave (
        input  IN_DATA, IN_VALID, TX_READY, CLR_OVF,
        output TX_DATA, TX_VALID, OVERFLOW, FIFO_COUNT, BUSY
    );

endinterface

// File: rtl/alu_res_fifo.sv
// Synchronous result FIFO; pointers carry an extra MSB so full/empty fall out of their difference.
module alu_res_fifo
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_OUT_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_r;
    logic [PW-1:0]         rd_ptr_r;

    // Read/write pointers, cleared by reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Storage array; a write to a full FIFO lands in the slot being read out this same edge.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];
    assign count   = wr_ptr_r - rd_ptr_r;
    assign full    = (count == PW'(FIFO_DEPTH));
    assign empty   = (count == PW'(0));

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams them LSB byte first over valid/ready.
// Define ALU_SER_HDR_EN to prefix every frame with the HDR_BYTE header.
module alu_result_serializer
    import alu_sys_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_OUT_W,
    parameter int FIFO_DEPTH = 4
`ifdef ALU_SER_HDR_EN
    ,
    parameter logic [BYTE_W-1:0] HDR_BYTE = SER_HDR
`endif
) (
    input  logic                     CLK,
    input  logic                     RST,
    alu_result_serializer_if.slave   bus
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BC_W-1:0] LAST_BC = BC_W'(NBYTES - 1);
`ifdef ALU_SER_HDR_EN
    localparam ser_state_e LOAD_ST = ST_HDR;
`else
    localparam ser_state_e LOAD_ST = ST_SEND;
`endif

    ser_state_e            state_r;
    ser_state_e            state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] shift_nxt_s;
    logic [BC_W-1:0]       byte_cnt_r;
    logic [BC_W-1:0]       byte_cnt_nxt_s;
    logic [BYTE_W-1:0]     tx_data_r;
    logic [BYTE_W-1:0]     tx_data_nxt_s;
    logic                  tx_valid_r;
    logic                  tx_valid_nxt_s;
    logic                  ovf_r;

    logic                  xfer_s;
    logic                  last_byte_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] fifo_rd_data_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CNT_W-1:0]      fifo_count_s;

    assign xfer_s      = tx_valid_r && bus.TX_READY;
    assign last_byte_s = (byte_cnt_r == LAST_BC);
    // A pop on this edge frees a slot, so a write to a full FIFO still succeeds.
    assign push_s      = bus.IN_VALID && (!fifo_full_s || pop_s);
    assign drop_s      = bus.IN_VALID && fifo_full_s && !pop_s;

    alu_res_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (push_s),
        .wr_data (bus.IN_DATA),
        .rd_en   (pop_s),
        .rd_data (fifo_rd_data_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = LOAD_ST;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
`ifdef ALU_SER_HDR_EN
            ST_HDR: begin
                if (xfer_s) begin
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_HDR;
                end
            end
`endif
            ST_SEND: begin
                if (xfer_s && last_byte_s) begin
                    state_nxt_s = fifo_empty_s ? ST_IDLE : LOAD_ST;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop and next values of the byte shifter and TX registers.
    always_comb begin
        pop_s          = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        tx_valid_nxt_s = tx_valid_r;
        shift_nxt_s    = shift_r;
        byte_cnt_nxt_s = byte_cnt_r;
        case (state_r)
            ST_IDLE: begin
                pop_s = !fifo_empty_s;
            end
`ifdef ALU_SER_HDR_EN
            ST_HDR: begin
                if (xfer_s) begin
                    tx_data_nxt_s = shift_r[BYTE_W-1:0];
                    shift_nxt_s   = shift_r >> BYTE_W;
                end else begin
                    tx_data_nxt_s = tx_data_r;
                end
            end
`endif
            ST_SEND: begin
                if (xfer_s && !last_byte_s) begin
                    tx_data_nxt_s  = shift_r[BYTE_W-1:0];
                    shift_nxt_s    = shift_r >> BYTE_W;
                    byte_cnt_nxt_s = byte_cnt_r + BC_W'(1);
                end else if (xfer_s) begin
                    pop_s          = !fifo_empty_s;
                    tx_valid_nxt_s = 1'b0;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                tx_valid_nxt_s = 1'b0;
            end
        endcase
        // Loading a fresh word overrides the end-of-frame drop, giving back-to-back frames.
        if (pop_s) begin
            tx_valid_nxt_s = 1'b1;
            byte_cnt_nxt_s = BC_W'(0);
`ifdef ALU_SER_HDR_EN
            tx_data_nxt_s  = HDR_BYTE;
            shift_nxt_s    = fifo_rd_data_s;
`else
            tx_data_nxt_s  = fifo_rd_data_s[BYTE_W-1:0];
            shift_nxt_s    = fifo_rd_data_s >> BYTE_W;
`endif
        end else begin
            byte_cnt_nxt_s = byte_cnt_nxt_s;
        end
    end

    // Byte shifter and registered TX outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_r    <= {DATA_WIDTH{1'b0}};
            byte_cnt_r <= BC_W'(0);
            tx_data_r  <= {BYTE_W{1'b0}};
            tx_valid_r <= 1'b0;
        end else begin
            shift_r    <= shift_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign bus.TX_DATA    = tx_data_r;
    assign bus.TX_VALID   = tx_valid_r;
    assign bus.OVERFLOW   = ovf_r;
    assign bus.FIFO_COUNT = fifo_count_s;
    assign bus.BUSY       = (state_r != ST_IDLE) || (fifo_count_s != CNT_W'(0));

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer; expected streams include the header when ALU_SER_HDR_EN is defined.
module tb_alu_result_serializer;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

`ifdef ALU_SER_HDR_EN
    localparam int HDR_N = 1;
`else
    localparam int HDR_N = 0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    logic [7:0] exp_q[$];
    vec_t       vecs[6];

    alu_result_serializer_if #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) bus_if ();

    alu_result_serializer #(.DATA_WIDTH(16), .FIFO_DEPTH(4)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_if)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Record every byte that will transfer on the coming rising edge.
    always @(negedge CLK) begin
        if (RST && bus_if.TX_VALID && bus_if.TX_READY) begin
            got_q.push_back(bus_if.TX_DATA);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_bytes(input logic [7:0] b0, input logic [7:0] b1);
        if (HDR_N != 0) exp_q.push_back(8'hA5);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((bus_if.BUSY || bus_if.TX_VALID) && n < 100) begin
            step();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(n < 100), 32'd1);
    endtask

    task automatic compare_stream(input string name);
        check({name, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    task automatic clear_streams();
        got_q.delete();
        got_cyc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] first;

        vecs[0] = '{16'h1234, 8'h34, 8'h12};
        vecs[1] = '{16'h00FF, 8'hFF, 8'h00};
        vecs[2] = '{16'hFF00, 8'h00, 8'hFF};
        vecs[3] = '{16'hA55A, 8'h5A, 8'hA5};
        vecs[4] = '{16'h8001, 8'h01, 8'h80};
        vecs[5] = '{16'h0000, 8'h00, 8'h00};

        bus_if.IN_DATA  = 16'h0000;
        bus_if.IN_VALID = 1'b0;
        bus_if.TX_READY = 1'b0;
        bus_if.CLR_OVF  = 1'b0;
        #1;
        check("rst_tx_data",  bus_if.TX_DATA, 32'h0);
        check("rst_tx_valid", bus_if.TX_VALID, 32'h0);
        check("rst_overflow", bus_if.OVERFLOW, 32'h0);
        check("rst_count",    bus_if.FIFO_COUNT, 32'h0);
        check("rst_busy",     bus_if.BUSY, 32'h0);
        repeat (2) step();
        RST = 1'b1;
        step();

        // Single words, sink always ready.
        for (int v = 0; v < 6; v++) begin
            clear_streams();
            bus_if.TX_READY = 1'b1;
            bus_if.IN_DATA  = vecs[v].data;
            bus_if.IN_VALID = 1'b1;
            step();
            bus_if.IN_VALID = 1'b0;
            check($sformatf("t1_v%0d_valid_k", v), bus_if.TX_VALID, 32'h0);
            check($sformatf("t1_v%0d_count_k", v), bus_if.FIFO_COUNT, 32'h1);
            check($sformatf("t1_v%0d_busy_k", v), bus_if.BUSY, 32'h1);
            step();
            first = (HDR_N != 0) ? 8'hA5 : vecs[v].b0;
            check($sformatf("t1_v%0d_valid_k1", v), bus_if.TX_VALID, 32'h1);
            check($sformatf("t1_v%0d_data_k1", v), bus_if.TX_DATA, first);
            drain("t1");
            expect_bytes(vecs[v].b0, vecs[v].b1);
            compare_stream($sformatf("t1_v%0d", v));
            check($sformatf("t1_v%0d_busy_end", v), bus_if.BUSY, 32'h0);
        end

        // Backpressure holds the first byte stable.
        clear_streams();
        bus_if.TX_READY = 1'b0;
        bus_if.IN_DATA  = 16'hBEEF;
        bus_if.IN_VALID = 1'b1;
        step();
        bus_if.IN_VALID = 1'b0;
        step();
        first = (HDR_N != 0) ? 8'hA5 : 8'hEF;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_hold_valid%0d", i), bus_if.TX_VALID, 32'h1);
            check($sformatf("t2_hold_data%0d", i), bus_if.TX_DATA, first);
            step();
        end
        bus_if.TX_READY = 1'b1;
        drain("t2");
        expect_bytes(8'hEF, 8'hBE);
        compare_stream("t2");

        // Overflow, set-wins clear, then a write accepted while full on the pop edge.
        clear_streams();
        bus_if.TX_READY = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus_if.IN_DATA  = 16'(i);
            bus_if.IN_VALID = 1'b1;
            step();
        end
        bus_if.IN_VALID = 1'b0;
        check("t3_ovf_set", bus_if.OVERFLOW, 32'h1);
        check("t3_count_full", bus_if.FIFO_COUNT, 32'h4);
        bus_if.IN_DATA  = 16'h0007;
        bus_if.IN_VALID = 1'b1;
        bus_if.CLR_OVF  = 1'b1;
        step();
        bus_if.IN_VALID = 1'b0;
        check("t3_ovf_set_wins", bus_if.OVERFLOW, 32'h1);
        check("t3_count_after_drop", bus_if.FIFO_COUNT, 32'h4);
        step();
        bus_if.CLR_OVF = 1'b0;
        check("t3_ovf_cleared", bus_if.OVERFLOW, 32'h0);
        bus_if.TX_READY = 1'b1;
        repeat (HDR_N + 1) step();
        bus_if.IN_DATA  = 16'h0077;
        bus_if.IN_VALID = 1'b1;
        step();
        bus_if.IN_VALID = 1'b0;
        check("t3_full_pop_no_ovf", bus_if.OVERFLOW, 32'h0);
        check("t3_full_pop_count", bus_if.FIFO_COUNT, 32'h4);
        drain("t3");
        for (int i = 1; i <= 5; i++) expect_bytes(8'(i), 8'h00);
        expect_bytes(8'h77, 8'h00);
        compare_stream("t3");

        // Back-to-back words stream without bubbles.
        clear_streams();
        bus_if.TX_READY = 1'b1;
        bus_if.IN_VALID = 1'b1;
        bus_if.IN_DATA  = 16'hA1B2;
        step();
        bus_if.IN_DATA  = 16'hC3D4;
        step();
        bus_if.IN_DATA  = 16'hE5F6;
        step();
        bus_if.IN_VALID = 1'b0;
        drain("t4");
        expect_bytes(8'hB2, 8'hA1);
        expect_bytes(8'hD4, 8'hC3);
        expect_bytes(8'hF6, 8'hE5);
        compare_stream("t4");
        if (got_q.size() > 0)
            check("t4_contiguous", got_cyc_q[got_cyc_q.size()-1] - got_cyc_q[0], got_q.size() - 1);

        // Two back-to-back words (header frame shape when enabled).
        clear_streams();
        bus_if.IN_VALID = 1'b1;
        bus_if.IN_DATA  = 16'h1234;
        step();
        bus_if.IN_DATA  = 16'h5678;
        step();
        bus_if.IN_VALID = 1'b0;
        drain("t6");
        expect_bytes(8'h34, 8'h12);
        expect_bytes(8'h78, 8'h56);
        compare_stream("t6");

        // Reset mid-frame discards the pending byte and the queued word.
        clear_streams();
        bus_if.IN_VALID = 1'b1;
        bus_if.IN_DATA  = 16'h5566;
        step();
        bus_if.IN_DATA  = 16'h7788;
        step();
        bus_if.IN_VALID = 1'b0;
        repeat (HDR_N + 1) step();
        check("t5_pending_55", bus_if.TX_DATA, 32'h55);
        bus_if.TX_READY = 1'b0;
        RST = 1'b0;
        #1;
        check("t5_rst_valid", bus_if.TX_VALID, 32'h0);
        check("t5_rst_count", bus_if.FIFO_COUNT, 32'h0);
        check("t5_rst_ovf", bus_if.OVERFLOW, 32'h0);
        check("t5_rst_busy", bus_if.BUSY, 32'h0);
        repeat (2) step();
        RST = 1'b1;
        bus_if.TX_READY = 1'b1;
        got_q.delete();
        repeat (10) step();
        check("t5_no_bytes_after_rst", got_q.size(), 32'h0);
        check("t5_idle_valid", bus_if.TX_VALID, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
